command_sequencer: RTL and testbench

//  Upstream feeder for the command-word decoder of the two-core multiplier datapath.

---
 rtl/command_sequencer.sv | 171 +++++++++++++++++
 tb/tb_command_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_sequencer.sv
// command_sequencer: walks a small program of command words, issuing each one to the
// multiplier decoder and holding until every addressed core reports completion.
module command_sequencer #(
  parameter int Data   = 32,
  parameter int Depth  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [Data-1:0]   i_prog_data,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_core1_done,
  input  logic              i_core2_done,
  output logic [Data-1:0]   o_cmd_out,
  output logic              o_cmd_valid,
  output logic              o_busy,
  output logic              o_seq_done,
  output logic              o_seq_err,
  output logic [ADDR_W-1:0] o_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_ADV
  } state_t;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Depth - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [Data-1:0]   r_mem [Depth];
  logic [Data-1:0]   r_rdata;
  logic [Data-1:0]   r_cmd;
  logic [Data-1:0]   w_cmd;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc;
  logic              r_valid;
  logic              w_valid;
  logic              r_done;
  logic              w_done;
  logic              r_err;
  logic              w_err;
  logic              r_lat1;
  logic              w_lat1;
  logic              r_lat2;
  logic              w_lat2;
  logic              w_halt;
  logic              w_need1;
  logic              w_need2;
  logic              w_got1;
  logic              w_got2;

  assign w_halt  = (r_rdata[31:28] == 4'hF);
  assign w_need1 = |r_rdata[11:10];
  assign w_need2 = |r_rdata[19:18];
  assign w_got1  = r_lat1 | i_core1_done;
  assign w_got2  = r_lat2 | i_core2_done;

  // Program store keeps its contents across reset; writes are accepted only while idle.
  always_ff @(posedge i_clk) begin
    if (i_prog_we && (r_state == S_IDLE)) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
    if (r_state == S_FETCH) begin
      r_rdata <= r_mem[r_pc];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cmd   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_lat1  <= 1'b0;
      r_lat2  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc;
      r_cmd   <= w_cmd;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_err   <= w_err;
      r_lat1  <= w_lat1;
      r_lat2  <= w_lat2;
    end
  end

  // Latches are only meaningful in WAIT; they are preloaded for cores the word does not use.
  always_comb begin
    w_next_state = r_state;
    w_pc         = r_pc;
    w_cmd        = r_cmd;
    w_valid      = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_lat1       = r_lat1;
    w_lat2       = r_lat2;
    if (i_abort) begin
      w_next_state = S_IDLE;
      w_lat1       = 1'b0;
      w_lat2       = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            w_next_state = S_FETCH;
            w_pc         = '0;
          end
        end
        S_FETCH: begin
          w_next_state = S_ISSUE;
        end
        S_ISSUE: begin
          if (w_halt) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_cmd   = r_rdata;
            w_valid = 1'b1;
            if (w_need1 || w_need2) begin
              w_lat1       = ~w_need1;
              w_lat2       = ~w_need2;
              w_next_state = S_WAIT;
            end else begin
              w_next_state = S_ADV;
            end
          end
        end
        S_WAIT: begin
          if (w_got1 && w_got2) begin
            w_lat1       = 1'b0;
            w_lat2       = 1'b0;
            w_next_state = S_ADV;
          end else begin
            w_lat1 = w_got1;
            w_lat2 = w_got2;
          end
        end
        S_ADV: begin
          if (r_pc == LastAddr) begin
            w_err        = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_pc         = r_pc + 1'b1;
            w_next_state = S_FETCH;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_out   = r_cmd;
  assign o_cmd_valid = r_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_seq_done  = r_done;
  assign o_seq_err   = r_err;
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_command_sequencer.sv
// Testbench for command_sequencer: programs are checked against an event-time model
// that predicts the cycle of every issue, completion and error from the word contents.
module tb_command_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        abort;
  logic        core1_done;
  logic        core2_done;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic        busy;
  logic        seq_done;
  logic        seq_err;
  logic [3:0]  pc;

  int          nVec = 0;
  int          nErr = 0;
  logic [31:0] prog [16];
  logic [31:0] lastOut = 32'h0;

  always #5 clk = ~clk;

  command_sequencer #(.Data(32), .Depth(16), .ADDR_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_prog_we    (prog_we),
    .i_prog_addr  (prog_addr),
    .i_prog_data  (prog_data),
    .i_start      (start),
    .i_abort      (abort),
    .i_core1_done (core1_done),
    .i_core2_done (core2_done),
    .o_cmd_out    (cmd_out),
    .o_cmd_valid  (cmd_valid),
    .o_busy       (busy),
    .o_seq_done   (seq_done),
    .o_seq_err    (seq_err),
    .o_pc         (pc)
  );

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Cycle c is measured from the cycle in which start is presented. An issued word at
  // cycle V is followed by the next issue at V+3, plus (latest needed pulse offset + 1)
  // when cores are involved; running off the end raises seq_err one cycle after the
  // last word's wait ends.
  task automatic run_program(input string tag, input int maxDly, input int f1, input int f2,
                             input bit junkWrite, input bit extras);
    bit          p1 [520];
    bit          p2 [520];
    int          nextEvt, endCyc, addr, d1, d2, d, extra;
    bit          finished, n1, n2, expValid, expDone, expErr, expBusy, chkPc;
    logic [31:0] word;
    logic [3:0]  expPc;
    for (int i = 0; i < 520; i++) begin
      p1[i] = 1'b0;
      p2[i] = 1'b0;
    end
    nextEvt  = 3;
    endCyc   = -1;
    addr     = 0;
    finished = 1'b0;
    expPc    = 4'h0;
    for (int c = 0; c < 500 && !finished; c++) begin
      @(negedge clk);
      expValid = 1'b0;
      expDone  = 1'b0;
      expErr   = 1'b0;
      expBusy  = (c != 0);
      chkPc    = 1'b0;
      if (c == endCyc) begin
        expErr   = 1'b1;
        expBusy  = 1'b0;
        finished = 1'b1;
        chkPc    = 1'b1;
        expPc    = 4'hF;
      end else if (endCyc < 0 && c == nextEvt) begin
        word  = prog[addr];
        chkPc = 1'b1;
        expPc = 4'(addr);
        if (word[31:28] == 4'hF) begin
          expDone  = 1'b1;
          expBusy  = 1'b0;
          finished = 1'b1;
        end else begin
          expValid = 1'b1;
          lastOut  = word;
          n1 = |word[11:10];
          n2 = |word[19:18];
          d1 = (f1 >= 0) ? f1 : int'($urandom_range(maxDly, 0));
          d2 = (f2 >= 0) ? f2 : int'($urandom_range(maxDly, 0));
          d  = 0;
          if (n1) begin
            p1[c + d1] = 1'b1;
            d = d1;
          end
          if (n2) begin
            p2[c + d2] = 1'b1;
            if (d2 > d) d = d2;
          end
          extra = (n1 || n2) ? d + 1 : 0;
          if (extras) begin
            if (n1 && d1 < d) p1[c + d] = 1'b1;
            if (n2 && d2 < d) p2[c + d] = 1'b1;
          end
          if (addr == 15) begin
            endCyc = c + 1 + extra;
          end else begin
            nextEvt = c + 3 + extra;
            addr++;
            if (extras && $urandom_range(1, 0) == 1) begin
              p1[nextEvt - 1] = 1'b1;
              p2[nextEvt - 1] = 1'b1;
            end
          end
        end
      end
      nVec++;
      if (cmd_valid !== expValid) begin
        nErr++;
        $display("[TB] FAIL %s cmd_valid cyc=%0d got=%b exp=%b", tag, c, cmd_valid, expValid);
      end
      nVec++;
      if (seq_done !== expDone) begin
        nErr++;
        $display("[TB] FAIL %s seq_done cyc=%0d got=%b exp=%b", tag, c, seq_done, expDone);
      end
      nVec++;
      if (seq_err !== expErr) begin
        nErr++;
        $display("[TB] FAIL %s seq_err cyc=%0d got=%b exp=%b", tag, c, seq_err, expErr);
      end
      nVec++;
      if (busy !== expBusy) begin
        nErr++;
        $display("[TB] FAIL %s busy cyc=%0d got=%b exp=%b", tag, c, busy, expBusy);
      end
      nVec++;
      if (cmd_out !== lastOut) begin
        nErr++;
        $display("[TB] FAIL %s cmd_out cyc=%0d got=%h exp=%h", tag, c, cmd_out, lastOut);
      end
      if (chkPc) begin
        nVec++;
        if (pc !== expPc) begin
          nErr++;
          $display("[TB] FAIL %s pc cyc=%0d got=%0d exp=%0d", tag, c, pc, expPc);
        end
      end
      if (finished) begin
        start      = 1'b0;
        core1_done = 1'b0;
        core2_done = 1'b0;
        prog_we    = 1'b0;
      end else begin
        start      = (c == 0) || (extras && c > 0 && $urandom_range(7, 0) == 0);
        core1_done = p1[c];
        core2_done = p2[c];
        prog_we    = junkWrite && (c == 1 || c == 2);
        prog_addr  = (c == 1) ? 4'd0 : 4'd1;
        prog_data  = ~prog[(c == 1) ? 0 : 1];
      end
    end
    nVec++;
    if (!finished) begin
      nErr++;
      $display("[TB] FAIL %s timeout got=running exp=finished", tag);
    end
    start      = 1'b0;
    core1_done = 1'b0;
    core2_done = 1'b0;
    prog_we    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) got = 1'b1;
    end
    nVec++;
    if (!got) begin
      nErr++;
      $display("[TB] FAIL %s wait_valid got=none exp=pulse", tag);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 4'h0;
    prog_data  = 32'h0;
    start      = 1'b0;
    abort      = 1'b0;
    core1_done = 1'b0;
    core2_done = 1'b0;
    repeat (3) @(negedge clk);
    nVec += 6;
    if (cmd_out !== 32'h0) begin
      nErr++;
      $display("[TB] FAIL reset cmd_out got=%h exp=0", cmd_out);
    end
    if (cmd_valid !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset cmd_valid got=%b exp=0", cmd_valid);
    end
    if (busy !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset busy got=%b exp=0", busy);
    end
    if (seq_done !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset seq_done got=%b exp=0", seq_done);
    end
    if (seq_err !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset seq_err got=%b exp=0", seq_err);
    end
    if (pc !== 4'h0) begin
      nErr++;
      $display("[TB] FAIL reset pc got=%0d exp=0", pc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_core();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0001;
    prog[0] = 32'h0000_0400;
    prog[1] = 32'hF000_0000;
    load_prog();
    run_program("single_core", 0, 2, -1, 0, 0);
  endtask

  task automatic test_dual_core();
    prog[0] = 32'h000C_0C00;
    prog[1] = 32'h000C_0C00;
    prog[2] = 32'hF000_0000;
    load_prog();
    run_program("dual_apart", 0, 6, 1, 0, 0);
    run_program("dual_same", 0, 3, 3, 0, 0);
  endtask

  task automatic test_no_work();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0001;
    load_prog();
    run_program("no_work", 0, -1, -1, 0, 0);
    repeat (3) begin
      @(negedge clk);
      nVec += 3;
      if (pc !== 4'hF) begin
        nErr++;
        $display("[TB] FAIL no_wrap pc got=%0d exp=15", pc);
      end
      if (busy !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL no_wrap busy got=%b exp=0", busy);
      end
      if (cmd_valid !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL no_wrap cmd_valid got=%b exp=0", cmd_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        w = $urandom;
        if ($urandom_range(9, 0) == 0) w[31:28] = 4'hF;
        else if (w[31:28] == 4'hF) w[31:28] = 4'h0;
        if ($urandom_range(2, 0) == 0) begin
          w[11:10] = 2'b00;
          w[19:18] = 2'b00;
        end
        prog[i] = w;
      end
      load_prog();
      run_program("random", 5, -1, -1, 0, 1);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0001;
    prog[0] = 32'h0000_0400;
    prog[1] = 32'hF000_0000;
    load_prog();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("abort");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    nVec += 4;
    if (busy !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL abort busy got=%b exp=0", busy);
    end
    if (seq_done !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL abort seq_done got=%b exp=0", seq_done);
    end
    if (cmd_valid !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL abort cmd_valid got=%b exp=0", cmd_valid);
    end
    if (cmd_out !== 32'h0000_0400) begin
      nErr++;
      $display("[TB] FAIL abort cmd_out got=%h exp=00000400", cmd_out);
    end
    core1_done = 1'b1;
    @(negedge clk);
    core1_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      nVec += 3;
      if (busy !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL abort_stray busy got=%b exp=0", busy);
      end
      if (seq_done !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL abort_stray seq_done got=%b exp=0", seq_done);
      end
      if (cmd_valid !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL abort_stray cmd_valid got=%b exp=0", cmd_valid);
      end
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nVec++;
      if (busy !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL abort_start busy got=%b exp=0", busy);
      end
    end
    lastOut = 32'h0000_0400;
    run_program("abort_rerun", 4, -1, -1, 0, 1);
  endtask

  task automatic test_prog_we_busy();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0000_0001;
    prog[0] = 32'h0000_0400;
    prog[1] = 32'h000C_0000;
    prog[2] = 32'hF000_0000;
    load_prog();
    run_program("we_busy", 3, -1, -1, 1, 0);
    run_program("we_rerun", 3, -1, -1, 0, 0);
  endtask

  task automatic test_reset_mid();
    prog[0] = 32'h0000_0400;
    prog[1] = 32'hF000_0000;
    load_prog();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("reset_mid");
    rst_n = 1'b0;
    #1;
    nVec += 6;
    if (cmd_valid !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset_mid cmd_valid got=%b exp=0", cmd_valid);
    end
    if (busy !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset_mid busy got=%b exp=0", busy);
    end
    if (cmd_out !== 32'h0) begin
      nErr++;
      $display("[TB] FAIL reset_mid cmd_out got=%h exp=0", cmd_out);
    end
    if (pc !== 4'h0) begin
      nErr++;
      $display("[TB] FAIL reset_mid pc got=%0d exp=0", pc);
    end
    if (seq_done !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset_mid seq_done got=%b exp=0", seq_done);
    end
    if (seq_err !== 1'b0) begin
      nErr++;
      $display("[TB] FAIL reset_mid seq_err got=%b exp=0", seq_err);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    lastOut = 32'h0;
    run_program("after_reset", 4, -1, -1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_single_core();
    test_dual_core();
    test_no_work();
    test_random();
    test_abort();
    test_prog_we_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
